// File: rtl/transpose_arb.sv
// Two-requester AXI-Stream arbiter feeding a shared 8x8 transpose datapath; frames are locked, idle grants round-robin.
// Optional perf counters (cnt0, cnt1, stall_cnt) are built only when TRANSPOSE_ARB_PERF_EN is defined.
module transpose_arb #(
   parameter  int COEF_WIDTH = 32,
   parameter  int CNT_W      = 32,
   localparam int DATA_W     = 64 * COEF_WIDTH
) (
   input  logic              aclk,
   input  logic              areset,
   input  logic [DATA_W-1:0] s0_tdata,
   input  logic              s0_tvalid,
   output logic              s0_tready,
   input  logic              s0_tlast,
   input  logic [DATA_W-1:0] s1_tdata,
   input  logic              s1_tvalid,
   output logic              s1_tready,
   input  logic              s1_tlast,
   output logic [DATA_W-1:0] m_tdata,
   output logic              m_tvalid,
   input  logic              m_tready,
   output logic              m_tlast,
   output logic              m_tid,
   output logic              busy
`ifdef TRANSPOSE_ARB_PERF_EN
   ,
   output logic [CNT_W-1:0]  cnt0,
   output logic [CNT_W-1:0]  cnt1,
   output logic [CNT_W-1:0]  stall_cnt
`endif
);

   typedef enum logic [1:0] {IDLE = 2'd0, LOCK0 = 2'd1, LOCK1 = 2'd2} state_t;

   state_t              state_q, state_d;
   logic                rr_q, rr_d;
   logic                m_tvalid_q, m_tvalid_d;
   logic                m_tlast_q, m_tlast_d;
   logic                m_tid_q, m_tid_d;
   logic [DATA_W-1:0]   m_tdata_q, m_tdata_d;

   logic                load;
   logic                sel;
   logic                s0_acc, s1_acc, acc;
   logic                sel_last;
   logic [DATA_W-1:0]   sel_data;

   always_comb begin
      // NOTE: every variable gets a default before any branch, so no path can infer a latch.
      sel        = 1'b0;
      state_d    = state_q;
      rr_d       = rr_q;
      m_tvalid_d = m_tvalid_q;
      m_tlast_d  = m_tlast_q;
      m_tid_d    = m_tid_q;
      m_tdata_d  = m_tdata_q;

      case (state_q)
         IDLE:    sel = (s0_tvalid && s1_tvalid) ? rr_q : s1_tvalid;
         LOCK0:   sel = 1'b0;
         LOCK1:   sel = 1'b1;
         default: sel = 1'b0;
      endcase

      load      = !m_tvalid_q || m_tready;
      s0_tready = !areset && load && !sel;
      s1_tready = !areset && load && sel;
      s0_acc    = s0_tvalid && s0_tready;
      s1_acc    = s1_tvalid && s1_tready;
      acc       = s0_acc || s1_acc;
      sel_data  = sel ? s1_tdata : s0_tdata;
      sel_last  = sel ? s1_tlast : s0_tlast;

      if (load) begin
         if (acc) begin
            m_tvalid_d = 1'b1;
            m_tdata_d  = sel_data;
            m_tlast_d  = sel_last;
            m_tid_d    = sel;
            // A frame holds the grant until its tlast beat, even across tvalid gaps.
            if (sel_last) begin
               state_d = IDLE;
               rr_d    = !sel;
            end else begin
               state_d = sel ? LOCK1 : LOCK0;
            end
         end else begin
            m_tvalid_d = 1'b0;
         end
      end
   end

   always_ff @(posedge aclk) begin
      if (areset) begin
         state_q    <= IDLE;
         rr_q       <= 1'b0;
         m_tvalid_q <= 1'b0;
         m_tlast_q  <= 1'b0;
         m_tid_q    <= 1'b0;
         // NOTE: the wide data register is cleared too, so m_tdata reads zero throughout reset.
         m_tdata_q  <= '0;
      end else begin
         // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
         state_q    <= state_d;
         rr_q       <= rr_d;
         m_tvalid_q <= m_tvalid_d;
         m_tlast_q  <= m_tlast_d;
         m_tid_q    <= m_tid_d;
         m_tdata_q  <= m_tdata_d;
      end
   end

   assign m_tdata  = m_tdata_q;
   assign m_tvalid = m_tvalid_q;
   assign m_tlast  = m_tlast_q;
   assign m_tid    = m_tid_q;
   assign busy     = (state_q != IDLE) || m_tvalid_q;

`ifdef TRANSPOSE_ARB_PERF_EN
   logic [CNT_W-1:0] cnt0_q, cnt0_d;
   logic [CNT_W-1:0] cnt1_q, cnt1_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

   // Counters wrap naturally at 2^CNT_W.
   always_comb begin
      cnt0_d      = cnt0_q;
      cnt1_d      = cnt1_q;
      stall_cnt_d = stall_cnt_q;
      if (s0_acc)                    cnt0_d      = cnt0_q + 1'b1;
      if (s1_acc)                    cnt1_d      = cnt1_q + 1'b1;
      if (m_tvalid_q && !m_tready)   stall_cnt_d = stall_cnt_q + 1'b1;
   end

   always_ff @(posedge aclk) begin
      if (areset) begin
         cnt0_q      <= '0;
         cnt1_q      <= '0;
         stall_cnt_q <= '0;
      end else begin
         cnt0_q      <= cnt0_d;
         cnt1_q      <= cnt1_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign cnt0      = cnt0_q;
   assign cnt1      = cnt1_q;
   assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_transpose_arb.sv
// Directed bench for transpose_arb: round-robin, frame lock, stall hold, lock gaps, mid-frame reset, counter wrap.
// Perf-counter checks are compiled in only when TRANSPOSE_ARB_PERF_EN is defined.
module tb_transpose_arb;
   localparam int COEF_WIDTH = 1;
   localparam int CNT_W      = 32;
   localparam int DATA_W     = 64 * COEF_WIDTH;

   logic              aclk = 1'b0;
   logic              areset;
   logic [DATA_W-1:0] s0_tdata, s1_tdata, m_tdata;
   logic              s0_tvalid, s0_tready, s0_tlast;
   logic              s1_tvalid, s1_tready, s1_tlast;
   logic              m_tvalid, m_tready, m_tlast, m_tid, busy;
`ifdef TRANSPOSE_ARB_PERF_EN
   logic [CNT_W-1:0]  cnt0, cnt1, stall_cnt;
`endif

   int n_checks = 0;
   int n_errors = 0;

   transpose_arb #(.COEF_WIDTH(COEF_WIDTH), .CNT_W(CNT_W)) dut (
      .aclk      (aclk),
      .areset    (areset),
      .s0_tdata  (s0_tdata),
      .s0_tvalid (s0_tvalid),
      .s0_tready (s0_tready),
      .s0_tlast  (s0_tlast),
      .s1_tdata  (s1_tdata),
      .s1_tvalid (s1_tvalid),
      .s1_tready (s1_tready),
      .s1_tlast  (s1_tlast),
      .m_tdata   (m_tdata),
      .m_tvalid  (m_tvalid),
      .m_tready  (m_tready),
      .m_tlast   (m_tlast),
      .m_tid     (m_tid),
      .busy      (busy)
`ifdef TRANSPOSE_ARB_PERF_EN
      ,
      .cnt0      (cnt0),
      .cnt1      (cnt1),
      .stall_cnt (stall_cnt)
`endif
   );

   always #5 aclk = ~aclk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Inputs change 1 time unit after a rising edge; combinational checks follow 1 unit later.
   task automatic drive(input logic v0, input logic [63:0] d0, input logic l0,
                        input logic v1, input logic [63:0] d1, input logic l1,
                        input logic rdy);
      s0_tvalid = v0; s0_tdata = d0; s0_tlast = l0;
      s1_tvalid = v1; s1_tdata = d1; s1_tlast = l1;
      m_tready  = rdy;
      #1;
   endtask

   task automatic tick();
      @(posedge aclk);
      #1;
   endtask

   initial begin
      areset = 1'b1;
      drive(1, 64'h1, 1, 1, 64'h2, 1, 1);
      tick();
      tick();
      check("rst_m_tvalid", m_tvalid, 0);
      check("rst_m_tid", m_tid, 0);
      check("rst_m_tdata", m_tdata, 0);
      check("rst_m_tlast", m_tlast, 0);
      check("rst_busy", busy, 0);
      check("rst_s0_tready", s0_tready, 0);
      check("rst_s1_tready", s1_tready, 0);
`ifdef TRANSPOSE_ARB_PERF_EN
      check("rst_cnt0", cnt0, 0);
      check("rst_stall", stall_cnt, 0);
`endif

      // Both requesters valid with single-beat frames: alternate 0,1,0,1.
      areset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         drive(1, 64'h100 + i, 1, 1, 64'h200 + i, 1, 1);
         check("rr_s0_tready", s0_tready, (i % 2) == 0);
         check("rr_s1_tready", s1_tready, (i % 2) == 1);
         tick();
         check("rr_m_tvalid", m_tvalid, 1);
         check("rr_m_tid", m_tid, i % 2);
         check("rr_m_tdata", m_tdata, ((i % 2) == 1) ? 64'h200 + i : 64'h100 + i);
         check("rr_m_tlast", m_tlast, 1);
      end

      // s0 three-beat frame while s1 stays valid.
      drive(1, 64'h301, 0, 1, 64'h3F0, 1, 1);
      check("lk_s0_tready_1", s0_tready, 1);
      check("lk_s1_tready_1", s1_tready, 0);
      tick();
      check("lk_tid_1", m_tid, 0);
      check("lk_data_1", m_tdata, 64'h301);
      check("lk_last_1", m_tlast, 0);
      drive(1, 64'h302, 0, 1, 64'h3F0, 1, 1);
      check("lk_s1_tready_2", s1_tready, 0);
      tick();
      check("lk_tid_2", m_tid, 0);
      check("lk_data_2", m_tdata, 64'h302);
      drive(1, 64'h303, 1, 1, 64'h3F0, 1, 1);
      check("lk_s1_tready_3", s1_tready, 0);
      tick();
      check("lk_tid_3", m_tid, 0);
      check("lk_last_3", m_tlast, 1);
      drive(0, 64'h0, 0, 1, 64'h3F0, 1, 1);
      check("lk_s1_tready_4", s1_tready, 1);
      tick();
      check("lk_tid_4", m_tid, 1);
      check("lk_data_4", m_tdata, 64'h3F0);

      // Stall with 0xA5 held for 4 cycles.
      drive(1, 64'hA5, 1, 0, 64'h0, 0, 1);
      check("st_s0_tready_load", s0_tready, 1);
      tick();
      check("st_data_load", m_tdata, 64'hA5);
      for (int i = 0; i < 4; i++) begin
         drive(1, 64'h5A, 1, 1, 64'h66, 1, 0);
         check("st_s0_tready", s0_tready, 0);
         check("st_s1_tready", s1_tready, 0);
         tick();
         check("st_m_tvalid", m_tvalid, 1);
         check("st_m_tdata", m_tdata, 64'hA5);
         check("st_m_tid", m_tid, 0);
      end
`ifdef TRANSPOSE_ARB_PERF_EN
      check("st_stall_cnt", stall_cnt, 4);
`endif
      drive(1, 64'h5A, 1, 0, 64'h0, 0, 1);
      check("st_s0_tready_resume", s0_tready, 1);
      tick();
      check("st_data_resume", m_tdata, 64'h5A);
      drive(0, 64'h0, 0, 0, 64'h0, 0, 1);
      tick();
      check("st_m_tvalid_drain", m_tvalid, 0);
      check("st_busy_drain", busy, 0);
`ifdef TRANSPOSE_ARB_PERF_EN
      check("pf_cnt0", cnt0, 7);
      check("pf_cnt1", cnt1, 3);
      check("pf_stall_cnt", stall_cnt, 4);
`endif

      // s1 locks, then drops tvalid for 2 cycles while s0 waits.
      drive(1, 64'h401, 1, 1, 64'h411, 0, 1);
      check("gp_s1_tready_1", s1_tready, 1);
      check("gp_s0_tready_1", s0_tready, 0);
      tick();
      check("gp_tid_1", m_tid, 1);
      check("gp_data_1", m_tdata, 64'h411);
      for (int i = 0; i < 2; i++) begin
         drive(1, 64'h401, 1, 0, 64'h0, 0, 1);
         check("gp_s0_tready_gap", s0_tready, 0);
         tick();
         check("gp_m_tvalid_gap", m_tvalid, 0);
         check("gp_busy_gap", busy, 1);
      end
      drive(1, 64'h401, 1, 1, 64'h412, 1, 1);
      check("gp_s0_tready_end", s0_tready, 0);
      check("gp_s1_tready_end", s1_tready, 1);
      tick();
      check("gp_tid_end", m_tid, 1);
      check("gp_data_end", m_tdata, 64'h412);
      drive(1, 64'h401, 1, 0, 64'h0, 0, 1);
      check("gp_s0_tready_after", s0_tready, 1);
      tick();
      check("gp_tid_after", m_tid, 0);
      check("gp_data_after", m_tdata, 64'h401);

      // Reset pulse while s1 holds a lock with a beat still on the output.
      drive(0, 64'h0, 0, 1, 64'h511, 0, 1);
      tick();
      check("rs_tid_lock", m_tid, 1);
      areset = 1'b1;
      drive(1, 64'h501, 1, 1, 64'h512, 1, 0);
      check("rs_s0_tready_in_rst", s0_tready, 0);
      check("rs_s1_tready_in_rst", s1_tready, 0);
      tick();
      check("rs_m_tvalid", m_tvalid, 0);
      check("rs_m_tdata", m_tdata, 0);
      check("rs_busy", busy, 0);
`ifdef TRANSPOSE_ARB_PERF_EN
      check("rs_cnt1", cnt1, 0);
      check("rs_stall_cnt", stall_cnt, 0);
`endif
      areset = 1'b0;
      drive(1, 64'h502, 1, 1, 64'h513, 1, 1);
      check("rs_s0_tready_first", s0_tready, 1);
      check("rs_s1_tready_first", s1_tready, 0);
      tick();
      check("rs_tid_first", m_tid, 0);
      check("rs_data_first", m_tdata, 64'h502);

`ifdef TRANSPOSE_ARB_PERF_EN
      // Preload cnt0 to all-ones, then one s0 beat wraps it to zero.
      drive(0, 64'h0, 0, 0, 64'h0, 0, 1);
      force dut.cnt0_d = '1;
      tick();
      release dut.cnt0_d;
      check("wr_cnt0_preload", cnt0, 64'hFFFF_FFFF);
      drive(1, 64'h601, 1, 0, 64'h0, 0, 1);
      tick();
      check("wr_cnt0_wrap", cnt0, 0);
`endif

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule

// File: doc/transpose_arb.md
TRANSPOSE_ARB -- requirements
Module: transpose_arb

Interface
REQ-001 The block SHALL have parameter COEF_WIDTH, default 32, giving the coefficient width in bits; one beat carries one 8x8 block, so DATA_W = 64*COEF_WIDTH.
REQ-002 The block SHALL have parameter CNT_W, default 32, giving the width of the performance counters.
REQ-003 aclk  in  1  single clock; all logic on its rising edge.
REQ-004 areset  in  1  reset, synchronous, active-high.
REQ-005 s0_tdata  in  DATA_W  requester-0 block; s0_tvalid in 1; s0_tready out 1; s0_tlast in 1 (end of frame).
REQ-006 s1_tdata  in  DATA_W  requester-1 block; s1_tvalid in 1; s1_tready out 1; s1_tlast in 1.
REQ-007 m_tdata  out  DATA_W  block to the shared transpose datapath; m_tvalid out 1; m_tready in 1; m_tlast out 1.
REQ-008 m_tid  out  1  index of the requester that sourced the current m_tdata.
REQ-009 busy  out  1  high when state is not IDLE or m_tvalid is high.
REQ-010 cnt0, cnt1  out  CNT_W each  beats accepted from s0 and from s1 (present only with TRANSPOSE_ARB_PERF_EN).
REQ-011 stall_cnt  out  CNT_W  cycles with m_tvalid=1 and m_tready=0 (present only with TRANSPOSE_ARB_PERF_EN).

Function
REQ-012 Output register: load = !m_tvalid || m_tready; m_tdata, m_tlast and m_tid update only when load is high and a beat is accepted.
REQ-013 On load with no beat accepted, m_tvalid SHALL fall to 0 if it was high and m_tready was high.
REQ-014 Latency from input handshake to m_tvalid SHALL be exactly 1 cycle; with m_tready held high, throughput SHALL be 1 beat per cycle.
REQ-015 The FSM SHALL have states IDLE, LOCK0 and LOCK1, plus a round-robin pointer rr (0 or 1).
REQ-016 IDLE selection: if only one sN_tvalid is high, select N; if both are high, select rr.
REQ-017 LOCKn selection: select n only; the other requester's tready SHALL be 0 even if that requester is valid.
REQ-018 sN_tready = load && (selected == N); an unselected tready SHALL be 0.
REQ-019 IDLE, accepted beat from N with tlast=0 -> LOCKN.
REQ-020 IDLE, accepted beat from N with tlast=1 -> stay IDLE, rr <= !N.
REQ-021 LOCKn, accepted beat with tlast=1 -> IDLE, rr <= !n; otherwise stay in LOCKn.
REQ-022 A frame (beats up to and including tlast) SHALL never interleave with the other requester's beats on m_*.
REQ-023 While m_tvalid=1 and m_tready=0, m_tdata, m_tlast and m_tid SHALL hold stable and both sN_tready SHALL be 0.
REQ-024 A requester deasserting tvalid inside its lock SHALL NOT release the lock; the FSM waits in LOCKn.
REQ-025 m_tid SHALL equal the index of the requester whose beat was loaded.

Reset
REQ-026 While areset=1, at every clock: state=IDLE, rr=0, m_tvalid=0, m_tlast=0, m_tid=0, m_tdata=0, and all counters=0.
REQ-027 During reset, s0_tready=0 and s1_tready=0.
REQ-028 Reset mid-frame SHALL drop the lock and any held beat; the first cycle after reset behaves as IDLE with rr=0.

Configuration
REQ-029 Macro TRANSPOSE_ARB_PERF_EN defined: cnt0, cnt1 and stall_cnt exist.
REQ-030 With the macro defined, each counter increments by 1 on its event and wraps from 2^CNT_W-1 to 0.
REQ-031 Macro undefined: the perf ports and counters are absent, and all other behaviour is identical.

Verification
REQ-032 Reset, then s0 and s1 both valid, tlast=1 each, m_tready=1 -> m_tid sequence 0,1,0,1; one beat per cycle; first m_tvalid 1 cycle after first handshake.
REQ-033 s0 sends a 3-beat frame (tlast on beat 3) while s1 stays valid -> m_tid=0,0,0 then 1; s1_tready=0 for the first 3 accept cycles.
REQ-034 m_tready=0 for 4 cycles with beat D=0xA5 held -> m_tdata stays 0xA5, both treadys=0, stall_cnt=4 (PERF_EN).
REQ-035 s1 in LOCK1 drops tvalid for 2 cycles while s0 is valid -> no s0 beat issued until s1 delivers tlast; then s0 is granted.
REQ-036 areset pulsed for 1 cycle mid-frame in LOCK1 -> m_tvalid=0 the next cycle; with both requesters valid, s0 is granted first.
REQ-037 cnt0 preloaded (forced) to 2^32-1, then one s0 beat accepted -> cnt0=0.
